rfc_resp: RTL

// - Responder end of the refresh req/gnt handshake: accepts refresh requests

---
 rtl/rfc_resp.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/rfc_resp.sv
// ---------------------------------------------------------------------------
// rfc_resp - refresh responder between the refresh timer and the SDRAM pins
//
// Accepts a refresh request from the refresh timer, stalls the main SDRAM
// controller until it reports idle, then grants. The grant cycle issues
// PRECHARGE-ALL, followed by AUTO-REFRESH after tRP. The block returns to idle
// once tRFC has elapsed.
//
// Parameters
//   TRP        PRECHARGE -> AUTO-REFRESH spacing in cycles (>= 1)
//   TRFC       AUTO-REFRESH -> next command spacing in cycles (>= 1)
//   TIMER_BITS wait-counter width, must hold max(TRP,TRFC)-1
//
// Ports
//   clk_i    in   1  clock
//   rst_i    in   1  asynchronous reset, active-high
//   en_i     in   1  accept new refresh requests when high
//   req_i    in   1  refresh request, held by the timer until gnt_o
//   gnt_o    out  1  one-cycle grant, coincident with the PRECHARGE cycle
//   idle_i   in   1  main controller has no open row / transaction
//   stall_o  out  1  main controller must not issue commands while high
//   cmd_o    out  3  {RAS_n,CAS_n,WE_n}: NOP=111, PRE=010, AREF=001
//   a10_o    out  1  high together with PRE (all banks)
//
// Build option
//   RFC_DOUBLE_EN  when defined, each grant issues two AUTO-REFRESH commands,
//                  each followed by a full tRFC wait. Used for SDRAM power-up
//                  initialisation.
// ---------------------------------------------------------------------------
module rfc_resp #(
  parameter int TRP        = 2,
  parameter int TRFC       = 7,
  parameter int TIMER_BITS = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       req_i,
  output logic       gnt_o,
  input  logic       idle_i,
  output logic       stall_o,
  output logic [2:0] cmd_o,
  output logic       a10_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PRE,
    ST_TRP,
    ST_AREF,
    ST_TRFC
  } state_t;

  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [2:0] CMD_PRE  = 3'b010;
  localparam logic [2:0] CMD_AREF = 3'b001;

  localparam logic [TIMER_BITS-1:0] TRP_LOAD  = TIMER_BITS'(TRP - 1);
  localparam logic [TIMER_BITS-1:0] TRFC_LOAD = TIMER_BITS'(TRFC - 1);
  localparam logic [TIMER_BITS-1:0] CNT_ONE   = TIMER_BITS'(1);

  state_t                r_state;
  state_t                w_nextState;
  logic [TIMER_BITS-1:0] r_cnt;
  logic [TIMER_BITS-1:0] w_nextCnt;
  logic                  w_nextGnt;
  logic                  w_nextStall;
  logic [2:0]            w_nextCmd;
  logic                  w_nextA10;
`ifdef RFC_DOUBLE_EN
  logic                  r_second;
  logic                  w_nextSecond;
`endif

  // Next-state and wait-counter logic. The counter is loaded on entry to
  // PRE and AREF; the wait states count it down to zero and only then move
  // on, so the command spacing is exactly TRP / TRFC cycles. With TRP or
  // TRFC equal to 1 the load value is already zero and the wait state is
  // skipped entirely.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
`ifdef RFC_DOUBLE_EN
    w_nextSecond = r_second;
`endif
    case (r_state)
      ST_IDLE: begin
        if (en_i && req_i) begin
          w_nextState = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A withdrawn request wins over a controller that just went idle.
        if (!req_i) begin
          w_nextState = ST_IDLE;
        end else if (idle_i) begin
          w_nextState = ST_PRE;
          w_nextCnt   = TRP_LOAD;
`ifdef RFC_DOUBLE_EN
          w_nextSecond = 1'b0;
`endif
        end
      end
      ST_PRE, ST_TRP: begin
        if (r_cnt == '0) begin
          w_nextState = ST_AREF;
          w_nextCnt   = TRFC_LOAD;
        end else begin
          w_nextState = ST_TRP;
          w_nextCnt   = r_cnt - CNT_ONE;
        end
      end
      ST_AREF, ST_TRFC: begin
        if (r_cnt == '0) begin
`ifdef RFC_DOUBLE_EN
          // First tRFC done: go round once more for the second refresh.
          if (!r_second) begin
            w_nextState  = ST_AREF;
            w_nextCnt    = TRFC_LOAD;
            w_nextSecond = 1'b1;
          end else begin
            w_nextState = ST_IDLE;
          end
`else
          w_nextState = ST_IDLE;
`endif
        end else begin
          w_nextState = ST_TRFC;
          w_nextCnt   = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they belong to on the same cycle.
  always_comb begin
    w_nextGnt   = 1'b0;
    w_nextA10   = 1'b0;
    w_nextCmd   = CMD_NOP;
    w_nextStall = (w_nextState != ST_IDLE);
    if (w_nextState == ST_PRE) begin
      w_nextGnt = 1'b1;
      w_nextA10 = 1'b1;
      w_nextCmd = CMD_PRE;
    end else if (w_nextState == ST_AREF) begin
      w_nextCmd = CMD_AREF;
    end
  end

  // State, counter and output registers. Reset forces everything back to
  // idle immediately, even in the middle of a refresh sequence.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      gnt_o   <= 1'b0;
      stall_o <= 1'b0;
      cmd_o   <= CMD_NOP;
      a10_o   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      gnt_o   <= w_nextGnt;
      stall_o <= w_nextStall;
      cmd_o   <= w_nextCmd;
      a10_o   <= w_nextA10;
    end
  end

`ifdef RFC_DOUBLE_EN
  // Tracks whether the second AUTO-REFRESH of the pair has been issued.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_second <= 1'b0;
    end else begin
      r_second <= w_nextSecond;
    end
  end
`endif

endmodule
